// File: rtl/tff_mon_pkg.sv
// Shared types and defaults for the T flip-flop toggle monitor.
// Holds the monitor state enum, the fault code enum and the default
// counter width / lock threshold used by tff_toggle_monitor.
package tff_mon_pkg;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned LOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISMATCH = 2'b01,
    FC_COMPL    = 2'b10
  } fault_code_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports: clk, rst_n (sync active-low), clr (sync clear), inc (count
// enable), count (current value; holds at all-ones).
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tff_toggle_monitor.sv
// Monitors an external T flip-flop: predicts its next Q from the current
// Q and T, locks after LOCK_CNT consecutive correct predictions, then
// counts Q toggles and latches a sticky fault on misprediction or when
// Q and Qbar stop being complementary.
// Ports: clk, rst_n (sync active-low), en (monitor enable), clr (sync
// clear), t_in/q_in/qbar_in (observed flip-flop), locked, fault,
// fault_code (00 none, 01 mismatch, 10 complement), err_pulse (one cycle
// on fault entry), toggle_cnt (saturating toggle count while locked).
module tff_toggle_monitor
  import tff_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             t_in,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic             err_pulse,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  mon_state_t  state;
  fault_code_t code;
  logic        pred;
  logic        prev_q;
  logic [3:0]  match_cnt;
  logic        mismatch;
  logic        compl_err;
  logic        toggle_inc;

  assign mismatch   = (q_in != pred);
  assign compl_err  = (q_in == qbar_in);
  assign fault_code = code;

  // A toggle counts only on an error-free, enabled TRACK edge that is not
  // being overridden by clr.
  assign toggle_inc = (state == ST_TRACK) && en && !clr && !compl_err &&
                      !mismatch && (q_in != prev_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      code      <= FC_NONE;
      pred      <= 1'b0;
      prev_q    <= 1'b0;
      match_cnt <= '0;
      locked    <= 1'b0;
      fault     <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      prev_q    <= q_in;
      if (clr) begin
        state     <= ST_IDLE;
        code      <= FC_NONE;
        match_cnt <= '0;
        locked    <= 1'b0;
        fault     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (en) begin
              state     <= ST_ACQUIRE;
              pred      <= q_in ^ t_in;
              match_cnt <= '0;
            end
          end
          ST_ACQUIRE: begin
            pred <= q_in ^ t_in;
            if (!en) begin
              state <= ST_IDLE;
            end else if (compl_err) begin
              state     <= ST_FAULT;
              code      <= FC_COMPL;
              fault     <= 1'b1;
              err_pulse <= 1'b1;
            end else if (mismatch) begin
              // Resynchronise: prediction restarts from this edge.
              match_cnt <= '0;
            end else begin
              match_cnt <= match_cnt + 4'd1;
              if ((match_cnt + 4'd1) == LOCK_TGT) begin
                state  <= ST_TRACK;
                locked <= 1'b1;
              end
            end
          end
          ST_TRACK: begin
            pred <= q_in ^ t_in;
            if (!en) begin
              state  <= ST_IDLE;
              locked <= 1'b0;
            end else if (compl_err || mismatch) begin
              // Complement error outranks a simultaneous mismatch.
              state     <= ST_FAULT;
              code      <= compl_err ? FC_COMPL : FC_MISMATCH;
              fault     <= 1'b1;
              err_pulse <= 1'b1;
              locked    <= 1'b0;
            end
          end
          ST_FAULT: begin
            state <= ST_FAULT;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_toggle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (toggle_inc),
    .count(toggle_cnt)
  );

endmodule

// File: tb/tb_tff_toggle_monitor.sv
module tb_tff_toggle_monitor;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LOCK_CNT = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             t_in;
  logic             q_in;
  logic             qbar_in;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;
  logic             err_pulse;
  logic [CNT_W-1:0] toggle_cnt;

  tff_toggle_monitor #(
    .CNT_W   (CNT_W),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .t_in      (t_in),
    .q_in      (q_in),
    .qbar_in   (qbar_in),
    .locked    (locked),
    .fault     (fault),
    .fault_code(fault_code),
    .err_pulse (err_pulse),
    .toggle_cnt(toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitored flip-flop (ideal behaviour) driven by the bench.
  logic tff_q = 1'b0;

  // Reference model: tracks the monitor's observable behaviour per edge.
  bit m_active, m_tracking, m_faulted, m_pulse, m_expect_q, m_last_q;
  int m_streak, m_code, m_count;

  task automatic model_step();
    bit miss, cerr;
    miss = (q_in != m_expect_q);
    cerr = (q_in == qbar_in);
    m_pulse = 1'b0;
    if (!rst_n) begin
      m_active = 0; m_tracking = 0; m_faulted = 0;
      m_streak = 0; m_code = 0; m_count = 0;
      m_expect_q = 0;
    end else if (clr) begin
      m_active = 0; m_tracking = 0; m_faulted = 0;
      m_streak = 0; m_code = 0; m_count = 0;
    end else if (m_faulted) begin
      // sticky
    end else if (!m_active) begin
      if (en) begin
        m_active = 1;
        m_streak = 0;
      end
    end else if (!en) begin
      m_active = 0;
      m_tracking = 0;
    end else if (cerr || (m_tracking && miss)) begin
      m_code = cerr ? 2 : 1;
      m_faulted = 1; m_pulse = 1;
      m_active = 0; m_tracking = 0;
    end else if (!m_tracking) begin
      m_streak = miss ? 0 : m_streak + 1;
      if (m_streak == LOCK_CNT) m_tracking = 1;
    end else if (q_in != m_last_q) begin
      m_count = (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
    end
    m_expect_q = q_in ^ t_in;
    m_last_q   = q_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    tff_q = tff_q ^ t_in;
    @(negedge clk);
    check_eq("locked",     int'(locked),     int'(m_tracking));
    check_eq("fault",      int'(fault),      int'(m_faulted));
    check_eq("fault_code", int'(fault_code), m_code);
    check_eq("err_pulse",  int'(err_pulse),  int'(m_pulse));
    check_eq("toggle_cnt", int'(toggle_cnt), m_count);
  endtask

  // Drive a well-behaved flip-flop view.
  task automatic drive(input logic e, input logic t, input logic c);
    en = e; t_in = t; clr = c;
    q_in = tff_q; qbar_in = ~tff_q;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0);
    repeat (2) tick();
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_cnt", int'(toggle_cnt), 0);
    rst_n = 1'b1;

    // Lock with constant toggling, then count 1,2,3.
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 0);
      tick();
      check_eq("lock_edge", int'(locked), (i == 5) ? 1 : 0);
    end
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 0);
      tick();
      check_eq("cnt_step", int'(toggle_cnt), i);
    end

    // Q held one cycle while T=1: prediction mismatch.
    drive(1, 1, 0);
    q_in = ~tff_q; qbar_in = tff_q;
    tick();
    check_eq("mis_fault", int'(fault), 1);
    check_eq("mis_code", int'(fault_code), 1);
    check_eq("mis_pulse", int'(err_pulse), 1);
    check_eq("mis_locked", int'(locked), 0);
    check_eq("mis_cnt", int'(toggle_cnt), 3);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0);
      tick();
      check_eq("fault_hold", int'(fault), 1);
      check_eq("pulse_once", int'(err_pulse), 0);
    end
    drive(1, 1, 1);
    tick();
    check_eq("clr_fault", int'(fault), 0);
    check_eq("clr_cnt", int'(toggle_cnt), 0);

    // Re-lock, then 20 toggles saturate a 4-bit counter.
    for (int i = 0; i < 5; i++) begin drive(1, 1, 0); tick(); end
    check_eq("relock", int'(locked), 1);
    for (int i = 0; i < 20; i++) begin drive(1, 1, 0); tick(); end
    check_eq("saturate", int'(toggle_cnt), CNT_MAX);

    // Complement error together with mismatch: complement code wins.
    for (int i = 0; i < 2 && tff_q; i++) begin drive(1, 1, 0); tick(); end
    drive(1, 1, 0);
    q_in = 1'b1; qbar_in = 1'b1;
    tick();
    check_eq("both_code", int'(fault_code), 2);
    check_eq("both_pulse", int'(err_pulse), 1);
    drive(0, 1, 1);
    tick();

    // clr with en during TRACK, then full re-acquisition needed.
    for (int i = 0; i < 8; i++) begin drive(1, 1, 0); tick(); end
    check_eq("pre_clr_lock", int'(locked), 1);
    drive(1, 1, 1);
    tick();
    check_eq("clr_en_lock", int'(locked), 0);
    check_eq("clr_en_cnt", int'(toggle_cnt), 0);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 0);
      tick();
      check_eq("reacq_edge", int'(locked), (i == 5) ? 1 : 0);
    end

    // Randomised traffic with occasional glitches, disables, clears, resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst_n = ($urandom_range(0, 249) != 0);
      drive(logic'($urandom_range(0, 24) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 79) == 0));
      r = $urandom_range(0, 59);
      if (r == 0) q_in = ~q_in;
      else if (r == 1) qbar_in = q_in;
      tick();
    end

    // Reset from arbitrary state.
    rst_n = 1'b0;
    drive(1, 1, 0);
    repeat (2) tick();
    check_eq("final_rst_locked", int'(locked), 0);
    check_eq("final_rst_fault", int'(fault), 0);
    check_eq("final_rst_code", int'(fault_code), 0);
    check_eq("final_rst_pulse", int'(err_pulse), 0);
    check_eq("final_rst_cnt", int'(toggle_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_toggle_monitor.md
TFF_TOGGLE_MONITOR -- requirements
Module: tff_toggle_monitor

Interface
REQ-001 Parameter: CNT_W, default 16, width of the toggle counter.
REQ-002 Parameter: LOCK_CNT, default 4, consecutive correct predictions required before lock (range 1..15).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: en  input  1  monitoring enable; level-sensitive.
REQ-006 Port: clr  input  1  synchronous clear of fault, counter and state.
REQ-007 Port: t_in  input  1  toggle request presented to the monitored T flip-flop.
REQ-008 Port: q_in  input  1  Q output of the monitored T flip-flop.
REQ-009 Port: qbar_in  input  1  Qbar output of the monitored T flip-flop.
REQ-010 Port: locked  output  1  high while in TRACK.
REQ-011 Port: fault  output  1  high while in FAULT (sticky).
REQ-012 Port: fault_code  output  2  00 none, 01 prediction mismatch, 10 complement error.
REQ-013 Port: err_pulse  output  1  single-cycle pulse on entry to FAULT.
REQ-014 Port: toggle_cnt  output  CNT_W  saturating count of observed Q toggles while locked.

Function
REQ-015 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-016 The monitor SHALL hold pred = q_in ^ t_in, sampled at every rising edge outside IDLE, as the expected q_in at the next edge.
REQ-017 Mismatch: q_in != pred at a rising edge in ACQUIRE or TRACK.
REQ-018 Complement error: q_in == qbar_in at a rising edge in ACQUIRE or TRACK.
REQ-019 States SHALL be IDLE, ACQUIRE, TRACK, FAULT.
REQ-020 IDLE: en=1 -> ACQUIRE; pred loaded; match counter = 0; no comparison that cycle.
REQ-021 ACQUIRE: match -> counter+1; counter reaching LOCK_CNT -> TRACK; mismatch -> counter = 0, stay in ACQUIRE (resync, no fault).
REQ-022 ACQUIRE: complement error -> FAULT, code 10.
REQ-023 TRACK: mismatch -> FAULT, code 01; complement error -> FAULT, code 10; both in the same cycle -> code 10.
REQ-024 TRACK: each edge with q_in != previous sampled q_in and no error SHALL increment toggle_cnt by 1, visible the next cycle.
REQ-025 toggle_cnt SHALL saturate at 2^CNT_W-1 and hold; it SHALL freeze outside TRACK and clear only on clr or reset.
REQ-026 en=0 in ACQUIRE or TRACK -> IDLE next cycle; toggle_cnt retained.
REQ-027 FAULT SHALL persist regardless of en or inputs until clr=1 or reset.
REQ-028 clr=1 SHALL force IDLE, fault=0, fault_code=00, toggle_cnt=0 next cycle; clr overrides en and any same-cycle detection.
REQ-029 err_pulse SHALL be high exactly one cycle, the cycle FAULT is first entered.
REQ-030 Latency: detection at edge k -> fault/locked/err_pulse updated in the cycle after edge k.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, locked=0, fault=0, fault_code=00, err_pulse=0, toggle_cnt=0, match counter=0, pred=0.
REQ-032 Reset SHALL take priority over clr and en, including mid-ACQUIRE, mid-TRACK or in FAULT.

Structure
REQ-033 Package tff_mon_pkg SHALL hold the state enum, the fault_code enum/constants and the default CNT_W/LOCK_CNT values.
REQ-034 Toggle counter SHALL be one sub-module, sat_counter (parameterised width, inc, clr, saturate).

Verification
REQ-035 rst_n=0 for 2 cycles from arbitrary state -> all outputs 0, state IDLE.
REQ-036 en=1, t_in=1 constant, correct T-FF model -> locked=1 in the cycle after the 5th edge following en; toggle_cnt then +1 per cycle (1,2,3...).
REQ-037 In TRACK, t_in=1 but q_in held one cycle -> fault=1, fault_code=01, err_pulse high 1 cycle, locked=0, toggle_cnt frozen; fault holds with en=1 for 10 cycles until clr.
REQ-038 In TRACK, q_in=qbar_in=1 while also mismatching -> fault_code=10.
REQ-039 CNT_W=4, t_in=1 for 20 cycles in TRACK -> toggle_cnt stops at 15.
REQ-040 clr=1 and en=1 in the same cycle during TRACK -> IDLE, toggle_cnt=0 next cycle; re-acquisition then needs LOCK_CNT matches again.
